voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Assigns incoming MIDI note-on/off events to synth voices and drives the note-event inputs of synth_engine
//  (keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off).
//  Sits between the MIDI decoder and synth_engine. Policy: retrigger the voice already holding the key,
//  else take the lowest free voice, else steal the oldest voice.
//  Holds note_on long enough for synth_engine's frame-rate sampling.
// PARAMETERS
//  VOICES     8    number of voices
//  V_WIDTH    3    log2(VOICES)
//  AGE_W      8    width of per-voice age counters (saturating)
//  NOTE_HOLD  256  OSC_CLK cycles note_on stays high; must be >= one xxxx frame; must be >= 1
// PORTS
//  OSC_CLK      in   1        sole clock, rising edge
//  reset_reg    in   1        asynchronous, active-high reset
//  ev_valid     in   1        event request
//  ev_ready     out  1        event accepted on ev_valid&&ev_ready; high only in IDLE
//  ev_on        in   1        1 = note on, 0 = note off
//  ev_key       in   8        key number (all 8 bits compared)
//  ev_vel       in   8        velocity (on or off)
//  all_notes_off in  1        level; panic clear
//  voice_free   in   VOICES   from env gen; 1 = envelope idle
//  keys_on      out  VOICES   per-voice gate
//  note_on      out  1        high NOTE_HOLD cycles per committed note-on
//  steal        out  1        high together with note_on when the voice was stolen
//  cur_key_adr  out  V_WIDTH  voice index of last committed event
//  cur_key_val  out  8        key of last committed note-on
//  cur_vel_on   out  8        velocity of last committed note-on
//  cur_vel_off  out  8        velocity of last committed note-off
// BEHAVIOUR
//  Reset: state IDLE; keys_on, note_on, steal, cur_* = 0; key table and ages = 0; ev_ready = 1.
//  FSM IDLE->SCAN->COMMIT->(HOLD|IDLE)
//  - IDLE: ev_ready=1. On accept, latch ev_on/key/vel and enter SCAN with i=0.
//  - SCAN: one voice per cycle, i=0..VOICES-1. voice_free[i] is sampled in the cycle voice i is scanned.
//    Tracked candidates:
//      match  = first i with keys_on[i] && key_tab[i]==key
//      free   = first i with voice_free[i] && !keys_on[i]
//      oldest = max age[i]; ties go to the lowest i
//    After i==VOICES-1, go to COMMIT.
//  - COMMIT, 1 cycle, note-on:
//      target = match ? match : free ? free : oldest
//      keys_on[target]<=1; key_tab[target]<=key; age[target]<=0
//      every other voice with keys_on=1: age += 1, saturating at 2^AGE_W-1
//      cur_key_adr, cur_key_val, cur_vel_on updated; note_on<=1; steal<=(no match && no free)
//      next state HOLD with counter = NOTE_HOLD-1
//  - COMMIT, note-off:
//      match found: keys_on[match]<=0; cur_key_adr<=match; cur_vel_off<=vel
//      no match: no output change
//      next state IDLE; note_on is not asserted
//  - HOLD: note_on and steal stay high; counter decrements; at 0, clear note_on and steal and go to IDLE.
//    ev_ready=0 throughout HOLD.
//  Latency: accept at edge 0; note_on first high in cycle VOICES+2; ev_ready high again in cycle VOICES+2+NOTE_HOLD.
//    Note-off: keys_on bit clears in cycle VOICES+2, and ev_ready is high in the same cycle.
//  all_notes_off=1 in any state:
//    next edge: keys_on=0, ages=0, note_on=0, steal=0, state IDLE; any pending event is dropped; cur_* unchanged
//    ev_ready=0 while all_notes_off is high
//  reset_reg mid-operation: immediate return to reset values; partial event is discarded.
//  cur_* hold their value between commits. keys_on changes only in COMMIT or on all_notes_off.
// STRUCTURE
//  Shared package synth_pkg: FSM state encoding (IDLE, SCAN, COMMIT, HOLD), AGE_W default, NOTE_HOLD default.
//  Sub-module voice_age_table: key_tab[VOICES] and age[VOICES] storage; indexed read port for the scan;
//    commit-write and saturating age-increment port; clear input.
//  Top module: FSM, scan candidate registers, hold counter, output registers.
// TESTING  (VOICES=8, NOTE_HOLD=4, voice_free=8'hFF unless stated)
//  1 reset; on key60 vel100 -> keys_on=8'h01, cur_key_adr=0, cur_key_val=60, cur_vel_on=100;
//    note_on high cycles 10..13 after accept; steal=0.
//  2 on key60 again -> retrigger voice 0; keys_on stays 8'h01; note_on pulse; age[0]=0.
//  3 on keys 61..67 (voices 1..7), voice_free=8'h00; then on key70 -> voice 0 (oldest) stolen;
//    steal=1 with note_on; key_tab[0]=70.
//  4 off key63 vel40 -> keys_on bit3 cleared, cur_key_adr=3, cur_vel_off=40, no note_on;
//    off key90 -> no output change.
//  5 all_notes_off pulsed during SCAN of a note-on -> keys_on=0 next edge; no note_on; ev_ready high after release.
//  6 reset_reg asserted during HOLD -> note_on, keys_on, cur_* = 0 before next clock edge; ev_ready=1 after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and defaults for the voice allocation path.
// Latency: n/a (types only).
// Backpressure: n/a.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int AGE_W_DEF     = 8;
    localparam int NOTE_HOLD_DEF = 256;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event request channel from the MIDI decoder into the voice allocator.
// Latency: n/a (wiring only).
// Backpressure: valid/ready; an event transfers when both are high on a clock edge.
interface voice_allocator_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [7:0] ev_key;
    logic [7:0] ev_vel;

    modport master (output ev_valid, ev_on, ev_key, ev_vel, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_key, ev_vel, output ev_ready);
endinterface

// File: rtl/voice_age_table.sv
// Per-voice key and age storage with a combinational scan read port.
// Latency: read is combinational; commit, age increment and clear land on the next edge.
// Backpressure: none; writes are accepted every cycle.
module voice_age_table #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3,
    parameter int AGE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [V_WIDTH-1:0] rd_idx,
    output logic [7:0]         rd_key,
    output logic [AGE_W-1:0]   rd_age,
    input  logic               wr_en,
    input  logic [V_WIDTH-1:0] wr_idx,
    input  logic [7:0]         wr_key,
    input  logic [VOICES-1:0]  inc_mask
);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [7:0]       key_tab_q [VOICES];
    logic [7:0]       key_tab_d [VOICES];
    logic [AGE_W-1:0] age_q     [VOICES];
    logic [AGE_W-1:0] age_d     [VOICES];

    assign rd_key = key_tab_q[rd_idx];
    assign rd_age = age_q[rd_idx];

    always_comb begin
        key_tab_d = key_tab_q;
        age_d     = age_q;
        if (clear) begin
            // Panic clear resets ages only; stale keys are harmless once keys_on is 0.
            for (int v = 0; v < VOICES; v++) age_d[v] = '0;
        end else if (wr_en) begin
            for (int v = 0; v < VOICES; v++) begin
                if (V_WIDTH'(v) == wr_idx) begin
                    key_tab_d[v] = wr_key;
                    age_d[v]     = '0;
                end else if (inc_mask[v] && age_q[v] != AGE_MAX) begin
                    age_d[v] = age_q[v] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                key_tab_q[v] <= '0;
                age_q[v]     <= '0;
            end
        end else begin
            key_tab_q <= key_tab_d;
            age_q     <= age_d;
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Maps note-on/off events to voices (retrigger, lowest free, else steal oldest) for synth_engine.
// Latency: VOICES+1 cycles accept-to-commit; note_on then held NOTE_HOLD cycles.
// Backpressure: ev_ready only in IDLE and never while all_notes_off is high.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int VOICES    = 8,
    parameter int V_WIDTH   = 3,
    parameter int AGE_W     = AGE_W_DEF,
    parameter int NOTE_HOLD = NOTE_HOLD_DEF
) (
    input  logic                OSC_CLK,
    input  logic                reset_reg,
    voice_allocator_if.slave    ev,
    input  logic                all_notes_off,
    input  logic [VOICES-1:0]   voice_free,
    output logic [VOICES-1:0]   keys_on,
    output logic                note_on,
    output logic                steal,
    output logic [V_WIDTH-1:0]  cur_key_adr,
    output logic [7:0]          cur_key_val,
    output logic [7:0]          cur_vel_on,
    output logic [7:0]          cur_vel_off
);
    localparam int HOLD_W = (NOTE_HOLD > 1) ? $clog2(NOTE_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(NOTE_HOLD - 1);
    localparam logic [V_WIDTH-1:0] LAST_IDX  = V_WIDTH'(VOICES - 1);

    state_t               state_q, state_d;
    logic                 ev_on_q, ev_on_d;
    logic [7:0]           ev_key_q, ev_key_d, ev_vel_q, ev_vel_d;
    logic [V_WIDTH-1:0]   scan_idx_q, scan_idx_d;
    logic                 match_vld_q, match_vld_d, free_vld_q, free_vld_d;
    logic [V_WIDTH-1:0]   match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
    logic [AGE_W-1:0]     old_age_q, old_age_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [VOICES-1:0]    keys_on_q, keys_on_d;
    logic                 note_on_q, note_on_d, steal_q, steal_d;
    logic [V_WIDTH-1:0]   cur_key_adr_q, cur_key_adr_d;
    logic [7:0]           cur_key_val_q, cur_key_val_d, cur_vel_on_q, cur_vel_on_d;
    logic [7:0]           cur_vel_off_q, cur_vel_off_d;

    logic                 tab_clear, tab_we;
    logic [V_WIDTH-1:0]   tab_wr_idx;
    logic [7:0]           rd_key;
    logic [AGE_W-1:0]     rd_age;
    logic [V_WIDTH-1:0]   target;

    voice_age_table #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .AGE_W(AGE_W)) u_table (
        .clk      (OSC_CLK),
        .rst      (reset_reg),
        .clear    (tab_clear),
        .rd_idx   (scan_idx_q),
        .rd_key   (rd_key),
        .rd_age   (rd_age),
        .wr_en    (tab_we),
        .wr_idx   (tab_wr_idx),
        .wr_key   (ev_key_q),
        .inc_mask (keys_on_q)
    );

    assign ev.ev_ready = (state_q == ST_IDLE) && !all_notes_off;

    always_comb begin
        state_d       = state_q;
        ev_on_d       = ev_on_q;
        ev_key_d      = ev_key_q;
        ev_vel_d      = ev_vel_q;
        scan_idx_d    = scan_idx_q;
        match_vld_d   = match_vld_q;
        match_idx_d   = match_idx_q;
        free_vld_d    = free_vld_q;
        free_idx_d    = free_idx_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        hold_cnt_d    = hold_cnt_q;
        keys_on_d     = keys_on_q;
        note_on_d     = note_on_q;
        steal_d       = steal_q;
        cur_key_adr_d = cur_key_adr_q;
        cur_key_val_d = cur_key_val_q;
        cur_vel_on_d  = cur_vel_on_q;
        cur_vel_off_d = cur_vel_off_q;
        tab_clear     = 1'b0;
        tab_we        = 1'b0;
        tab_wr_idx    = '0;
        target        = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : old_idx_q);

        if (all_notes_off) begin
            state_d   = ST_IDLE;
            keys_on_d = '0;
            note_on_d = 1'b0;
            steal_d   = 1'b0;
            tab_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ev.ev_valid) begin
                        ev_on_d     = ev.ev_on;
                        ev_key_d    = ev.ev_key;
                        ev_vel_d    = ev.ev_vel;
                        scan_idx_d  = '0;
                        match_vld_d = 1'b0;
                        free_vld_d  = 1'b0;
                        state_d     = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!match_vld_q && keys_on_q[scan_idx_q] && rd_key == ev_key_q) begin
                        match_vld_d = 1'b1;
                        match_idx_d = scan_idx_q;
                    end
                    if (!free_vld_q && voice_free[scan_idx_q] && !keys_on_q[scan_idx_q]) begin
                        free_vld_d = 1'b1;
                        free_idx_d = scan_idx_q;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (scan_idx_q == '0 || rd_age > old_age_q) begin
                        old_idx_d = scan_idx_q;
                        old_age_d = rd_age;
                    end
                    if (scan_idx_q == LAST_IDX) state_d = ST_COMMIT;
                    else                        scan_idx_d = scan_idx_q + V_WIDTH'(1);
                end
                ST_COMMIT: begin
                    if (ev_on_q) begin
                        keys_on_d[target] = 1'b1;
                        tab_we            = 1'b1;
                        tab_wr_idx        = target;
                        cur_key_adr_d     = target;
                        cur_key_val_d     = ev_key_q;
                        cur_vel_on_d      = ev_vel_q;
                        note_on_d         = 1'b1;
                        steal_d           = !match_vld_q && !free_vld_q;
                        hold_cnt_d        = HOLD_INIT;
                        state_d           = ST_HOLD;
                    end else begin
                        if (match_vld_q) begin
                            keys_on_d[match_idx_q] = 1'b0;
                            cur_key_adr_d          = match_idx_q;
                            cur_vel_off_d          = ev_vel_q;
                        end
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == '0) begin
                        note_on_d = 1'b0;
                        steal_d   = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge OSC_CLK or posedge reset_reg) begin
        if (reset_reg) begin
            state_q       <= ST_IDLE;
            ev_on_q       <= 1'b0;
            ev_key_q      <= '0;
            ev_vel_q      <= '0;
            scan_idx_q    <= '0;
            match_vld_q   <= 1'b0;
            match_idx_q   <= '0;
            free_vld_q    <= 1'b0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            hold_cnt_q    <= '0;
            keys_on_q     <= '0;
            note_on_q     <= 1'b0;
            steal_q       <= 1'b0;
            cur_key_adr_q <= '0;
            cur_key_val_q <= '0;
            cur_vel_on_q  <= '0;
            cur_vel_off_q <= '0;
        end else begin
            state_q       <= state_d;
            ev_on_q       <= ev_on_d;
            ev_key_q      <= ev_key_d;
            ev_vel_q      <= ev_vel_d;
            scan_idx_q    <= scan_idx_d;
            match_vld_q   <= match_vld_d;
            match_idx_q   <= match_idx_d;
            free_vld_q    <= free_vld_d;
            free_idx_q    <= free_idx_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            hold_cnt_q    <= hold_cnt_d;
            keys_on_q     <= keys_on_d;
            note_on_q     <= note_on_d;
            steal_q       <= steal_d;
            cur_key_adr_q <= cur_key_adr_d;
            cur_key_val_q <= cur_key_val_d;
            cur_vel_on_q  <= cur_vel_on_d;
            cur_vel_off_q <= cur_vel_off_d;
        end
    end

    assign keys_on     = keys_on_q;
    assign note_on     = note_on_q;
    assign steal       = steal_q;
    assign cur_key_adr = cur_key_adr_q;
    assign cur_key_val = cur_key_val_q;
    assign cur_vel_on  = cur_vel_on_q;
    assign cur_vel_off = cur_vel_off_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a reference allocation model pushes expected results per event.
// Latency: checks commit at cycle 10 and a 4-cycle note_on pulse (VOICES=8, NOTE_HOLD=4).
// Backpressure: waits on ev_ready with bounded loops before each event.
module tb_voice_allocator;
    localparam int VOICES    = 8;
    localparam int NOTE_HOLD = 4;

    logic       OSC_CLK = 1'b0;
    logic       reset_reg;
    logic       all_notes_off;
    logic [7:0] voice_free;
    logic [7:0] keys_on;
    logic       note_on, steal;
    logic [2:0] cur_key_adr;
    logic [7:0] cur_key_val, cur_vel_on, cur_vel_off;

    voice_allocator_if ev_if ();

    voice_allocator #(.VOICES(VOICES), .V_WIDTH(3), .AGE_W(8), .NOTE_HOLD(NOTE_HOLD)) dut (
        .OSC_CLK       (OSC_CLK),
        .reset_reg     (reset_reg),
        .ev            (ev_if),
        .all_notes_off (all_notes_off),
        .voice_free    (voice_free),
        .keys_on       (keys_on),
        .note_on       (note_on),
        .steal         (steal),
        .cur_key_adr   (cur_key_adr),
        .cur_key_val   (cur_key_val),
        .cur_vel_on    (cur_vel_on),
        .cur_vel_off   (cur_vel_off)
    );

    always #5 OSC_CLK = ~OSC_CLK;

    typedef struct {
        logic [7:0] keys_on;
        logic [2:0] adr;
        logic [7:0] val, von, voff;
        logic       steal;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [7:0] m_keys_on;
    logic [7:0] m_key [VOICES];
    int         m_age [VOICES];
    logic [2:0] m_adr;
    logic [7:0] m_val, m_von, m_voff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_keys_on = '0;
        for (int i = 0; i < VOICES; i++) begin m_key[i] = '0; m_age[i] = 0; end
        m_adr = '0; m_val = '0; m_von = '0; m_voff = '0;
    endtask

    // Reference allocation: retrigger, else lowest free, else oldest (lowest index on ties).
    task automatic model_event(input logic on, input logic [7:0] key, input logic [7:0] vel);
        int   match = -1, free = -1, oldest = 0, tgt;
        exp_t e;
        for (int i = 0; i < VOICES; i++) begin
            if (match < 0 && m_keys_on[i] && m_key[i] == key) match = i;
            if (free < 0 && voice_free[i] && !m_keys_on[i]) free = i;
            if (m_age[i] > m_age[oldest]) oldest = i;
        end
        e.steal = 1'b0;
        if (on) begin
            tgt = (match >= 0) ? match : ((free >= 0) ? free : oldest);
            e.steal = (match < 0) && (free < 0);
            for (int i = 0; i < VOICES; i++)
                if (i != tgt && m_keys_on[i] && m_age[i] < 255) m_age[i]++;
            m_age[tgt] = 0; m_keys_on[tgt] = 1'b1; m_key[tgt] = key;
            m_adr = 3'(tgt); m_val = key; m_von = vel;
        end else if (match >= 0) begin
            m_keys_on[match] = 1'b0; m_adr = 3'(match); m_voff = vel;
        end
        e.keys_on = m_keys_on; e.adr = m_adr; e.val = m_val; e.von = m_von; e.voff = m_voff;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!ev_if.ev_ready && c < 60) begin @(negedge OSC_CLK); c++; end
        if (c >= 60) check("ready_timeout", 32'(ev_if.ev_ready), 32'd1);
    endtask

    task automatic drive_event(input logic on, input logic [7:0] key, input logic [7:0] vel);
        ev_if.ev_valid = 1'b1; ev_if.ev_on = on; ev_if.ev_key = key; ev_if.ev_vel = vel;
        @(negedge OSC_CLK);
        ev_if.ev_valid = 1'b0;
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_keys_on"}, 32'(keys_on), 32'(e.keys_on));
        check({tag, "_adr"},     32'(cur_key_adr), 32'(e.adr));
        check({tag, "_val"},     32'(cur_key_val), 32'(e.val));
        check({tag, "_von"},     32'(cur_vel_on), 32'(e.von));
        check({tag, "_voff"},    32'(cur_vel_off), 32'(e.voff));
        check({tag, "_steal"},   32'(steal), 32'(e.steal));
    endtask

    task automatic run_event(input string tag, input logic on, input logic [7:0] key, input logic [7:0] vel);
        int lat = 0, w = 0, seen_on = 0;
        wait_ready();
        model_event(on, key, vel);
        drive_event(on, key, vel);
        if (on) begin
            for (int c = 1; c <= 40; c++) begin
                if (c > 1) @(negedge OSC_CLK);
                if (note_on) begin lat = c; break; end
            end
            check({tag, "_on_latency"}, 32'(lat), 32'd10);
            compare_outputs(tag);
            while (note_on && w < 100) begin w++; @(negedge OSC_CLK); end
            check({tag, "_pulse_len"}, 32'(w), 32'(NOTE_HOLD));
            check({tag, "_ready_after"}, 32'(ev_if.ev_ready), 32'd1);
        end else begin
            for (int c = 1; c <= 40; c++) begin
                if (c > 1) @(negedge OSC_CLK);
                if (note_on) seen_on++;
                if (ev_if.ev_ready) begin lat = c; break; end
            end
            check({tag, "_off_latency"}, 32'(lat), 32'd10);
            check({tag, "_no_note_on"}, 32'(seen_on), 32'd0);
            compare_outputs(tag);
        end
    endtask

    initial begin
        int seen;
        reset_reg = 1'b1; all_notes_off = 1'b0; voice_free = 8'hFF;
        ev_if.ev_valid = 1'b0; ev_if.ev_on = 1'b0; ev_if.ev_key = '0; ev_if.ev_vel = '0;
        model_reset();
        repeat (3) @(negedge OSC_CLK);
        check("rst_keys_on", 32'(keys_on), 32'd0);
        check("rst_note_on", 32'(note_on), 32'd0);
        check("rst_cur_val", 32'(cur_key_val), 32'd0);
        reset_reg = 1'b0;
        @(negedge OSC_CLK);
        check("rst_ready", 32'(ev_if.ev_ready), 32'd1);

        // Allocation, retrigger, fill, steal, and retrigger of the stolen voice.
        run_event("t1_on60", 1'b1, 8'd60, 8'd100);
        run_event("t2_retrig60", 1'b1, 8'd60, 8'd90);
        for (int k = 61; k <= 67; k++) run_event("t3_fill", 1'b1, 8'(k), 8'(k + 1));
        voice_free = 8'h00;
        run_event("t3_steal70", 1'b1, 8'd70, 8'd55);
        run_event("t3_retrig70", 1'b1, 8'd70, 8'd56);
        voice_free = 8'hFF;

        run_event("t4_off63", 1'b0, 8'd63, 8'd40);
        run_event("t4_off90", 1'b0, 8'd90, 8'd41);

        // Panic clear during the scan of a note-on drops the event.
        wait_ready();
        drive_event(1'b1, 8'd80, 8'd77);
        repeat (2) @(negedge OSC_CLK);
        all_notes_off = 1'b1;
        #1 check("t5_ready_low", 32'(ev_if.ev_ready), 32'd0);
        @(negedge OSC_CLK);
        m_keys_on = '0;
        for (int i = 0; i < VOICES; i++) m_age[i] = 0;
        check("t5_keys_on", 32'(keys_on), 32'(m_keys_on));
        check("t5_cur_adr_held", 32'(cur_key_adr), 32'(m_adr));
        all_notes_off = 1'b0;
        #1 check("t5_ready_high", 32'(ev_if.ev_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 15; c++) begin @(negedge OSC_CLK); if (note_on) seen++; end
        check("t5_no_note_on", 32'(seen), 32'd0);

        // After a panic clear, allocation starts again from voice 0.
        run_event("t5_realloc", 1'b1, 8'd33, 8'd44);

        // Asynchronous reset in HOLD.
        wait_ready();
        drive_event(1'b1, 8'd50, 8'd60);
        seen = 0;
        for (int c = 0; c < 40 && !note_on; c++) begin @(negedge OSC_CLK); seen++; end
        check("t6_note_on_seen", 32'(note_on), 32'd1);
        reset_reg = 1'b1;
        #1;
        check("t6_note_on", 32'(note_on), 32'd0);
        check("t6_keys_on", 32'(keys_on), 32'd0);
        check("t6_cur_adr", 32'(cur_key_adr), 32'd0);
        check("t6_cur_val", 32'(cur_key_val), 32'd0);
        check("t6_cur_von", 32'(cur_vel_on), 32'd0);
        check("t6_cur_voff", 32'(cur_vel_off), 32'd0);
        @(negedge OSC_CLK);
        reset_reg = 1'b0;
        #1 check("t6_ready", 32'(ev_if.ev_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
